load_reg_bank: RTL

Parametrised multi-channel loadable register bank: NCH independent WIDTH-bit registers, each with a per-channel op code (hold/load/increment/clear), a DEPTH-stage delayed copy of its data input, a saturating load counter and a stability flag. It generalises the single-channel load/hold register with one-cycle input delay that the SVA property examples use. It serves as a reusable design-under-test for assertion chapters needing multi-channel, multi-mode and multi-cycle temporal behaviour.

---
 rtl/load_reg_bank_pkg.sv | 19 +
 rtl/load_reg_bank_if.sv | 23 ++
 rtl/load_reg_chan.sv | 109 ++++++++++
 rtl/load_reg_bank.sv | 51 +++++
 4 files changed

// File: rtl/load_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_reg_bank_pkg
// Description : Shared op codes and constants for the load_reg_bank slice.
// Revision    : 1.0 - initial release
// ============================================================================
package load_reg_bank_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_LOAD = 2'b01,
        OP_INC  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    localparam int RUN_W = 8;

endpackage : load_reg_bank_pkg
`default_nettype wire

// File: rtl/load_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : load_reg_bank_if
// Description : Packed per-channel op/data inputs and register-bank outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_reg_bank_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int CNT_W = 4
);
    logic [2*NCH-1:0]     op;
    logic [WIDTH*NCH-1:0] d;
    logic [WIDTH*NCH-1:0] q;
    logic [WIDTH*NCH-1:0] d_r;
    logic [CNT_W*NCH-1:0] cnt;
    logic [NCH-1:0]       stable;

    modport master (output op, output d, input q, input d_r, input cnt, input stable);
    modport slave  (input op, input d, output q, output d_r, output cnt, output stable);

endinterface : load_reg_bank_if
`default_nettype wire

// File: rtl/load_reg_chan.sv
`default_nettype none
// ============================================================================
// Module      : load_reg_chan
// Description : One register channel: value, delay line, load counter and
//               stability tracking. Assertions enabled by LOAD_REG_BANK_SVA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module load_reg_chan
    import load_reg_bank_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 4,
    parameter int STABLE_CYC = 3
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic [1:0]       op,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q,
    output logic      [WIDTH-1:0] d_r,
    output logic      [CNT_W-1:0] cnt,
    output logic                  stable
);

    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [RUN_W-1:0] c_RUN_MAX  = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0] c_STAB_THR = RUN_W'(STABLE_CYC);

    logic [WIDTH-1:0]            val_q, val_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [RUN_W-1:0]            run_q, run_d;
    logic                        stable_q, stable_d;
    logic [DEPTH-1:0][WIDTH-1:0] dly_q, dly_d;

    always_comb begin
        val_d = val_q;
        cnt_d = cnt_q;
        case (op_e'(op))
            OP_LOAD: begin
                val_d = d;
                if (cnt_q != c_CNT_MAX) cnt_d = cnt_q + 1'b1;
            end
            OP_INC:  val_d = val_q + 1'b1;
            OP_CLR: begin
                val_d = '0;
                cnt_d = '0;
            end
            default: ;
        endcase

        // Run length compares the next value against the current one, so a
        // reload of the same value or a clear of zero keeps the run going.
        if (val_d != val_q)          run_d = '0;
        else if (run_q == c_RUN_MAX) run_d = run_q;
        else                         run_d = run_q + 1'b1;
        stable_d = (run_d >= c_STAB_THR);

        dly_d[0] = d;
        for (int i = 1; i < DEPTH; i++) dly_d[i] = dly_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            val_q    <= '0;
            cnt_q    <= '0;
            run_q    <= '0;
            stable_q <= 1'b0;
            dly_q    <= '0;
        end else begin
            val_q    <= val_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            stable_q <= stable_d;
            dly_q    <= dly_d;
        end
    end

    assign q      = val_q;
    assign d_r    = dly_q[DEPTH-1];
    assign cnt    = cnt_q;
    assign stable = stable_q;

`ifdef LOAD_REG_BANK_SVA_EN
    logic [31:0] since_rst_q;

    always_ff @(posedge clk) begin
        if (!reset_n)                 since_rst_q <= '0;
        else if (since_rst_q < DEPTH) since_rst_q <= since_rst_q + 1;
    end

    default clocking cb @(negedge clk); endclocking
    default disable iff (!reset_n);

    a_load: assert property (op == OP_LOAD |=> val_q == $past(d));
    a_hold: assert property (op == OP_HOLD |=> $stable(val_q));
    a_inc:  assert property (op == OP_INC  |=> val_q == WIDTH'($past(val_q) + 1'b1));
    a_clr:  assert property (op == OP_CLR  |=> (val_q == '0) && (cnt_q == '0));
    a_dr:   assert property (since_rst_q >= DEPTH |-> dly_q[DEPTH-1] == $past(d, DEPTH));
    a_cnt:  assert property (($past(reset_n) && (cnt_q < $past(cnt_q)))
                             |-> $past(op) == OP_CLR);
    a_stab: assert property (stable_q == (run_q >= c_STAB_THR));

    c_wrap: cover property (op == OP_INC && val_q == '1 ##1 val_q == '0);
    c_sat:  cover property (op == OP_LOAD && cnt_q == c_CNT_MAX);
`endif

endmodule : load_reg_chan
`default_nettype wire

// File: rtl/load_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : load_reg_bank
// Description : NCH-channel loadable register bank; packs/unpacks channel
//               slices. Optional assertions via LOAD_REG_BANK_SVA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module load_reg_bank
    import load_reg_bank_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NCH        = 4,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 4,
    parameter int STABLE_CYC = 3
) (
    input wire logic       clk,
    input wire logic       reset_n,
    load_reg_bank_if.slave bus
);

    logic [NCH-1:0][WIDTH-1:0] q_w;
    logic [NCH-1:0][WIDTH-1:0] d_r_w;
    logic [NCH-1:0][CNT_W-1:0] cnt_w;
    logic [NCH-1:0]            stable_w;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        load_reg_chan #(
            .WIDTH      (WIDTH),
            .DEPTH      (DEPTH),
            .CNT_W      (CNT_W),
            .STABLE_CYC (STABLE_CYC)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .op      (bus.op[2*c +: 2]),
            .d       (bus.d[WIDTH*c +: WIDTH]),
            .q       (q_w[c]),
            .d_r     (d_r_w[c]),
            .cnt     (cnt_w[c]),
            .stable  (stable_w[c])
        );
    end

    assign bus.q      = q_w;
    assign bus.d_r    = d_r_w;
    assign bus.cnt    = cnt_w;
    assign bus.stable = stable_w;

endmodule : load_reg_bank
`default_nettype wire
